lfa_adc_reader: RTL and testbench

- SPI master for the ADC128S022 8-channel 12-bit ADC that carries the three line-follower-array (LFA) sensors.
- Continuously scans the left, middle and right channels.
- Presents the latest 12-bit readings as registered outputs, which feed the line-following controller's left/middle/right inputs.
- Pulses data_valid once per complete three-channel scan, so downstream logic knows when a fresh, coherent set is available.

---
 rtl/lfa_adc_reader.sv | 207 ++++++++++++++++++++
 tb/tb_lfa_adc_reader.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfa_adc_reader.sv
// lfa_adc_reader: SPI master for the ADC128S022 that scans the left, middle and
// right line-follower sensors. It publishes a coherent left/middle/right set and
// pulses data_valid once per completed scan.
// QUIET_HP is expected to be at least 1 so that the chip-select gap is non-empty.
module lfa_adc_reader #(
    parameter int unsigned CLK_DIV  = 25,
    parameter logic [2:0]  LEFT_CH  = 3'd3,
    parameter logic [2:0]  MID_CH   = 3'd2,
    parameter logic [2:0]  RIGHT_CH = 3'd1,
    parameter int unsigned QUIET_HP = 2
) (
    input  logic        clk_50M,
    input  logic        reset,
    input  logic        enable,
    input  logic        adc_dout,
    output logic        adc_cs_n,
    output logic        adc_sck,
    output logic        adc_din,
    output logic [11:0] left,
    output logic [11:0] middle,
    output logic [11:0] right,
    output logic        data_valid
);

    localparam int unsigned DIV_W  = 6;
    localparam int unsigned EDGE_W = 5;
    localparam int unsigned GAP_W  = 8;
    localparam int unsigned DATA_W = 12;
    localparam int unsigned WORD_W = 16;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(31);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(QUIET_HP);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRAME = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t              state_q;
    logic [DIV_W-1:0]    div_q;
    logic [EDGE_W-1:0]   edge_q;
    logic [GAP_W-1:0]    gap_q;
    logic [1:0]          idx_q;
    logic [1:0]          cur_q;
    logic                prime_q;
    logic                done_q;
    logic [WORD_W-1:0]   tx_q;
    logic [DATA_W-1:0]   rx_q;
    logic                cs_n_q;
    logic                sck_q;
    logic                din_q;
    logic [DATA_W-1:0]   left_q;
    logic [DATA_W-1:0]   middle_q;
    logic [DATA_W-1:0]   right_q;
    logic                valid_q;

    logic                div_hit_c;
    logic [WORD_W-1:0]   word_c;

    // Channel address for a position in the left/middle/right sequence.
    function automatic logic [2:0] ch_addr(input logic [1:0] i);
        case (i)
            2'd0:    ch_addr = LEFT_CH;
            2'd1:    ch_addr = MID_CH;
            default: ch_addr = RIGHT_CH;
        endcase
    endfunction

    // Sequence position that follows i (wraps 2 -> 0).
    function automatic logic [1:0] idx_next(input logic [1:0] i);
        idx_next = (i == 2'd2) ? 2'd0 : 2'(i + 2'd1);
    endfunction

    // Sequence position that precedes i (wraps 0 -> 2).
    function automatic logic [1:0] idx_prev(input logic [1:0] i);
        idx_prev = (i == 2'd0) ? 2'd2 : 2'(i - 2'd1);
    endfunction

    // Half-period expiry and the control word for the next frame.
    assign div_hit_c = (div_q == DIV_LAST);
    assign word_c    = {2'b00, ch_addr(idx_q), 11'b0};

    // Scan sequencer: chip select, SCLK, shift registers and result routing.
    // rx_q keeps only the last 12 of the 16 shifted bits; the leading four
    // bits of every frame fall off the top and are never looked at.
    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            div_q    <= '0;
            edge_q   <= '0;
            gap_q    <= '0;
            idx_q    <= 2'd0;
            cur_q    <= 2'd0;
            prime_q  <= 1'b1;
            done_q   <= 1'b0;
            tx_q     <= '0;
            rx_q     <= '0;
            cs_n_q   <= 1'b1;
            sck_q    <= 1'b1;
            din_q    <= 1'b0;
            left_q   <= '0;
            middle_q <= '0;
            right_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;

            // A finished frame carries the conversion addressed one frame earlier.
            if (done_q) begin
                if (!prime_q) begin
                    case (idx_prev(cur_q))
                        2'd0:    left_q   <= rx_q;
                        2'd1:    middle_q <= rx_q;
                        default: begin
                            right_q <= rx_q;
                            valid_q <= 1'b1;
                        end
                    endcase
                end
                prime_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    cs_n_q <= 1'b1;
                    sck_q  <= 1'b1;
                    if (enable) begin
                        state_q <= FRAME;
                        cs_n_q  <= 1'b0;
                        div_q   <= '0;
                        edge_q  <= '0;
                        tx_q    <= word_c;
                        rx_q    <= '0;
                        cur_q   <= idx_q;
                        idx_q   <= idx_next(idx_q);
                    end
                end

                FRAME: begin
                    if (div_hit_c) begin
                        div_q  <= '0;
                        sck_q  <= ~sck_q;
                        edge_q <= EDGE_W'(edge_q + 1'b1);
                        if (sck_q) begin
                            din_q <= tx_q[WORD_W-1];
                            tx_q  <= {tx_q[WORD_W-2:0], 1'b0};
                        end else begin
                            rx_q <= {rx_q[DATA_W-2:0], adc_dout};
                            if (edge_q == EDGE_LAST) begin
                                done_q  <= 1'b1;
                                gap_q   <= '0;
                                state_q <= GAP;
                            end
                        end
                    end else begin
                        div_q <= DIV_W'(div_q + 1'b1);
                    end
                end

                GAP: begin
                    if (div_hit_c) begin
                        div_q <= '0;
                        gap_q <= GAP_W'(gap_q + 1'b1);
                        if (gap_q == '0) begin
                            cs_n_q <= 1'b1;
                        end
                        if (gap_q == GAP_LAST) begin
                            if (enable) begin
                                state_q <= FRAME;
                                cs_n_q  <= 1'b0;
                                edge_q  <= '0;
                                tx_q    <= word_c;
                                rx_q    <= '0;
                                cur_q   <= idx_q;
                                idx_q   <= idx_next(idx_q);
                            end else begin
                                state_q <= IDLE;
                                prime_q <= 1'b1;
                            end
                        end
                    end else begin
                        div_q <= DIV_W'(div_q + 1'b1);
                    end
                end

                default: begin
                    state_q <= IDLE;
                    cs_n_q  <= 1'b1;
                    sck_q   <= 1'b1;
                end
            endcase
        end
    end

    // Registered outputs.
    assign adc_cs_n   = cs_n_q;
    assign adc_sck    = sck_q;
    assign adc_din    = din_q;
    assign left       = left_q;
    assign middle     = middle_q;
    assign right      = right_q;
    assign data_valid = valid_q;

endmodule

// File: tb/tb_lfa_adc_reader.sv
// tb_lfa_adc_reader: ADC128S022 behavioural model plus a scoreboard that derives
// the expected readings from the addresses the DUT actually sends.
module tb_lfa_adc_reader;

    localparam int unsigned D         = 25;
    localparam int unsigned Q         = 2;
    localparam int unsigned FRAME_CYC = (33 + Q) * D;
    localparam logic [2:0]  L_CH      = 3'd3;
    localparam logic [2:0]  M_CH      = 3'd2;
    localparam logic [2:0]  R_CH      = 3'd1;

    logic        clk_50M = 1'b0;
    logic        reset   = 1'b1;
    logic        enable  = 1'b0;
    logic        adc_dout = 1'b0;
    logic        adc_cs_n, adc_sck, adc_din, data_valid;
    logic [11:0] left, middle, right;

    logic        enable2  = 1'b0;
    logic        adc_dout2 = 1'b0;
    logic        cs2, sck2, din2, valid2;
    logic [11:0] left2, middle2, right2;

    lfa_adc_reader u_dut (
        .clk_50M(clk_50M), .reset(reset), .enable(enable), .adc_dout(adc_dout),
        .adc_cs_n(adc_cs_n), .adc_sck(adc_sck), .adc_din(adc_din),
        .left(left), .middle(middle), .right(right), .data_valid(data_valid)
    );

    lfa_adc_reader #(.CLK_DIV(8)) u_dut8 (
        .clk_50M(clk_50M), .reset(reset), .enable(enable2), .adc_dout(adc_dout2),
        .adc_cs_n(cs2), .adc_sck(sck2), .adc_din(din2),
        .left(left2), .middle(middle2), .right(right2), .data_valid(valid2)
    );

    always #10 clk_50M = ~clk_50M;

    int cyc = 0;
    always @(posedge clk_50M) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [2:0] seq_addr(input int i);
        case (i)
            0:       seq_addr = L_CH;
            1:       seq_addr = M_CH;
            default: seq_addr = R_CH;
        endcase
    endfunction

    // ADC conversion values per channel address (what the sensors "see").
    logic [11:0] val  [8];
    logic [11:0] val2 [8];

    // Scoreboard / ADC model state.
    logic [11:0] exp_l = '0, exp_m = '0, exp_r = '0;
    logic        exp_v = 1'b0;
    logic        exp_prime = 1'b1;
    int          exp_idx = 0;
    int          fcnt = 0, fall_n = 0, rise_n = 0, low_cyc = 0, high_cyc = 0;
    logic        in_frame = 1'b0, cs_p = 1'b1, sck_p = 1'b1;
    logic [15:0] rx_w = '0, resp_w = '0;
    logic [2:0]  adc_last = 3'd0, resp_addr = 3'd0;
    logic        frame_prime = 1'b0;
    logic        pend = 1'b0, pend_prime = 1'b0;
    logic [11:0] pend_val = '0;
    logic [2:0]  pend_addr = '0;
    logic        idle_ok = 1'b0;
    logic [2:0]  addr_log [$];

    // ADC model and per-cycle output comparison.
    always @(negedge clk_50M) begin
        exp_v = 1'b0;
        if (reset) begin
            exp_l = '0; exp_m = '0; exp_r = '0;
            exp_idx = 0; exp_prime = 1'b1; fcnt = 0; pend = 1'b0;
            fall_n = 0; rise_n = 0; in_frame = 1'b0; cs_p = 1'b1; sck_p = 1'b1;
            high_cyc = 0; low_cyc = 0; idle_ok = 1'b0;
        end else if (pend) begin
            pend = 1'b0;
            if (!pend_prime) begin
                if (pend_addr == L_CH) exp_l = pend_val;
                else if (pend_addr == M_CH) exp_m = pend_val;
                else if (pend_addr == R_CH) begin
                    exp_r = pend_val;
                    exp_v = 1'b1;
                end
            end
        end

        check("left", 32'(left), 32'(exp_l));
        check("middle", 32'(middle), 32'(exp_m));
        check("right", 32'(right), 32'(exp_r));
        check("data_valid", 32'(data_valid), 32'(exp_v));

        if (!reset) begin
            if (cs_p && !adc_cs_n) begin
                if (idle_ok && high_cyc > int'(Q * D)) begin
                    exp_prime = 1'b1;
                    idle_ok = 1'b0;
                end else if (fcnt > 0) begin
                    check("cs_gap_cycles", 32'(high_cyc), 32'(Q * D));
                end
                fcnt++;
                in_frame = 1'b1; fall_n = 0; rise_n = 0; rx_w = '0;
                resp_addr = adc_last;
                resp_w = {4'b1010, val[adc_last]};
                frame_prime = exp_prime;
                low_cyc = 0;
            end
            if (!cs_p && adc_cs_n && in_frame) begin
                in_frame = 1'b0;
                check("sclk_falls", 32'(fall_n), 32'd16);
                check("sclk_rises", 32'(rise_n), 32'd16);
                check("cs_low_cycles", 32'(low_cyc), 32'(33 * D));
                check("ctrl_word", 32'(rx_w), 32'({2'b00, seq_addr(exp_idx), 11'b0}));
                adc_last = rx_w[13:11];
                addr_log.push_back(rx_w[13:11]);
                exp_idx = (exp_idx + 1) % 3;
                exp_prime = 1'b0;
                high_cyc = 0;
            end
            if (!adc_cs_n && in_frame) begin
                if (sck_p && !adc_sck) begin
                    fall_n++;
                    if (fall_n <= 16) adc_dout = resp_w[16 - fall_n];
                end
                if (!sck_p && adc_sck) begin
                    rise_n++;
                    rx_w = {rx_w[14:0], adc_din};
                    if (rise_n == 16) begin
                        pend = 1'b1;
                        pend_val = resp_w[11:0];
                        pend_addr = resp_addr;
                        pend_prime = frame_prime;
                    end
                end
            end
            if (adc_cs_n) high_cyc++;
            else low_cyc++;
            cs_p = adc_cs_n;
            sck_p = adc_sck;
        end
    end

    // Minimal ADC model for the CLK_DIV = 8 instance.
    logic        cs2_p = 1'b1, sck2_p = 1'b1;
    int          f2 = 0, fall_cyc2 = 0, hp2 = 0;
    logic [15:0] rx2 = '0, resp2 = '0;
    logic [2:0]  last2 = '0;
    always @(negedge clk_50M) begin
        if (reset) begin
            cs2_p = 1'b1; sck2_p = 1'b1; f2 = 0;
        end else begin
            if (cs2_p && !cs2) begin
                f2 = 0; rx2 = '0;
                resp2 = {4'b0110, val2[last2]};
            end
            if (!cs2) begin
                if (sck2_p && !sck2) begin
                    f2++;
                    fall_cyc2 = cyc;
                    if (f2 <= 16) adc_dout2 = resp2[16 - f2];
                end
                if (!sck2_p && sck2) begin
                    hp2 = cyc - fall_cyc2;
                    rx2 = {rx2[14:0], din2};
                end
            end
            if (!cs2_p && cs2) last2 = rx2[13:11];
            cs2_p = cs2;
            sck2_p = sck2;
        end
    end

    task automatic tick();
        @(posedge clk_50M);
        #2;
    endtask

    task automatic wait_cs_fall(input string name, output int at);
        bit seen_hi;
        seen_hi = 1'b0;
        at = -1;
        for (int n = 0; n < int'(3 * FRAME_CYC); n++) begin
            @(negedge clk_50M);
            #1;
            if (adc_cs_n === 1'b1) seen_hi = 1'b1;
            else if (seen_hi) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            tests++; fails++;
            $display("FAIL %s: adc_cs_n fall not seen within budget", name);
        end
    endtask

    task automatic wait_valid(input string name, output int at);
        at = -1;
        for (int n = 0; n < int'(5 * FRAME_CYC); n++) begin
            @(negedge clk_50M);
            #1;
            if (data_valid === 1'b1) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            tests++; fails++;
            $display("FAIL %s: data_valid not seen within budget", name);
        end
    endtask

    initial begin
        int t0, t1, t2, fc, base, got;
        logic [11:0] pat;

        for (int i = 0; i < 8; i++) begin
            val[i] = 12'h123;
            val2[i] = 12'h456;
        end
        val[3] = 12'h0A5; val[2] = 12'h7FF; val[1] = 12'h000;
        val2[3] = 12'h5A3; val2[2] = 12'h3C0; val2[1] = 12'hABC;

        // Reset state.
        repeat (3) @(posedge clk_50M);
        #1;
        check("rst_cs_n", 32'(adc_cs_n), 32'd1);
        check("rst_sck", 32'(adc_sck), 32'd1);
        check("rst_din", 32'(adc_din), 32'd0);
        check("rst_left", 32'(left), 32'd0);
        check("rst_valid", 32'(data_valid), 32'd0);
        check("rst_cs2_n", 32'(cs2), 32'd1);
        tick(); reset = 1'b0;
        tick(); enable = 1'b1;

        // Continuous scan: first coherent set after the 4th frame.
        wait_cs_fall("first_frame", t0);
        wait_valid("first_valid", t1);
        check("first_valid_latency", 32'(t1 - t0), 32'd3426);
        check("scan1_left", 32'(left), 32'h0A5);
        check("scan1_middle", 32'(middle), 32'h7FF);
        check("scan1_right", 32'(right), 32'h000);
        wait_valid("second_valid", t2);
        check("valid_spacing", 32'(t2 - t1), 32'd2625);
        check("addr_frame1", 32'(addr_log[0]), 32'd3);
        check("addr_frame2", 32'(addr_log[1]), 32'd2);
        check("addr_frame3", 32'(addr_log[2]), 32'd1);

        // Alternating all-ones / LSB-only scans.
        for (int k = 0; k < 4; k++) begin
            tick();
            pat = (k % 2 == 0) ? 12'hFFF : 12'h001;
            val[3] = pat; val[2] = pat; val[1] = pat;
            wait_valid("alt_valid", got);
            check("alt_left", 32'(left), 32'(pat));
            check("alt_middle", 32'(middle), 32'(pat));
            check("alt_right", 32'(right), 32'(pat));
        end

        // Drop enable a few SCLK edges into the frame that addresses RIGHT.
        tick();
        val[3] = 12'h0A5; val[2] = 12'h7FF; val[1] = 12'h000;
        for (int k = 0; k < 4; k++) begin
            wait_cs_fall("drop_frame", got);
            if (exp_idx == 2) break;
        end
        for (int n = 0; n < int'(8 * D); n++) begin
            @(negedge clk_50M);
            #1;
            if (fall_n + rise_n >= 5) break;
        end
        tick();
        enable = 1'b0;
        idle_ok = 1'b1;
        fc = fcnt;
        repeat (2 * FRAME_CYC) @(posedge clk_50M);
        #2;
        check("idle_no_new_frame", 32'(fcnt), 32'(fc));
        check("idle_cs_n", 32'(adc_cs_n), 32'd1);
        check("idle_sck", 32'(adc_sck), 32'd1);
        check("hold_left", 32'(left), 32'h0A5);
        check("hold_middle", 32'(middle), 32'h7FF);
        check("hold_right", 32'(right), 32'h001);
        enable = 1'b1;
        wait_cs_fall("reenable_frame", t0);
        wait_valid("reenable_valid", t1);
        check("reenable_latency", 32'(t1 - t0), 32'd3426);
        check("reenable_right", 32'(right), 32'h000);

        // Asynchronous reset at the 10th rising edge of frame 3.
        tick(); reset = 1'b1;
        tick(); tick(); reset = 1'b0;
        for (int n = 0; n < int'(4 * FRAME_CYC); n++) begin
            @(posedge clk_50M);
            if (fcnt == 3 && rise_n == 10) break;
        end
        #3;
        check("pre_reset_left", 32'(left), 32'h0A5);
        reset = 1'b1;
        #1;
        check("async_rst_cs_n", 32'(adc_cs_n), 32'd1);
        check("async_rst_sck", 32'(adc_sck), 32'd1);
        check("async_rst_left", 32'(left), 32'd0);
        check("async_rst_middle", 32'(middle), 32'd0);
        check("async_rst_right", 32'(right), 32'd0);
        repeat (3) @(posedge clk_50M);
        #2;
        reset = 1'b0;
        base = addr_log.size();
        wait_cs_fall("restart_frame", t0);
        wait_valid("restart_valid", t1);
        check("restart_latency", 32'(t1 - t0), 32'd3426);
        check("restart_first_addr", 32'(addr_log[base]), 32'd3);
        check("restart_left", 32'(left), 32'h0A5);
        check("restart_middle", 32'(middle), 32'h7FF);

        // CLK_DIV = 8 instance.
        tick(); enable2 = 1'b1;
        t0 = -1; t1 = -1;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk_50M);
            #1;
            if (t0 < 0 && cs2 === 1'b0) t0 = cyc;
            if (valid2 === 1'b1) begin
                t1 = cyc;
                break;
            end
        end
        if (t1 < 0) begin
            tests++; fails++;
            $display("FAIL div8_valid: data_valid not seen within budget");
        end
        check("div8_latency", 32'(t1 - t0), 32'd1097);
        check("div8_half_period", 32'(hp2), 32'd8);
        check("div8_left", 32'(left2), 32'h5A3);
        check("div8_middle", 32'(middle2), 32'h3C0);
        check("div8_right", 32'(right2), 32'hABC);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
